// File: rtl/tcp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tcp_pkg : word/count types and lane constants shared by the tcp TX stages.
// Revision: 1.0
// ----------------------------------------------------------------------------
package tcp_pkg;

  localparam int BYTE_LANES = 8;

  typedef logic [63:0] tcp_word_t;
  typedef logic [2:0]  tcp_cnt_t;
  typedef logic [3:0]  tcp_fill_t;

  // Places a byte into lane n (lane 0 = [63:56]) of an otherwise zero word.
  function automatic tcp_word_t place_byte(input logic [7:0] b, input logic [2:0] lane);
    tcp_word_t w;
    w = {b, 56'd0};
    return w >> {lane, 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tcp_tx_packer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tcp_tx_packer_if : byte-stream input and word-stream output of the packer.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface tcp_tx_packer_if;
  import tcp_pkg::*;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  tcp_word_t  tx_data;
  tcp_cnt_t   tx_cnt;
  logic       tx_valid;
  logic       tx_ready;

  // Environment side: byte source and word sink.
  modport master (
    output in_data, in_valid, in_last, tx_ready,
    input  in_ready, tx_data, tx_cnt, tx_valid
  );

  // Packer side.
  modport slave (
    input  in_data, in_valid, in_last, tx_ready,
    output in_ready, tx_data, tx_cnt, tx_valid
  );

endinterface
`default_nettype wire

// File: rtl/tcp_tx_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tcp_tx_packer : packs an MSB-first byte stream into 64-bit words for tcp TX.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tcp_tx_packer
  import tcp_pkg::*;
#(
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       con_ready,
  tcp_tx_packer_if.slave  bus
);

  localparam logic [16:0] TIMEOUT_L  = 17'(FLUSH_TIMEOUT);
  localparam bit          TIMEOUT_EN = (FLUSH_TIMEOUT != 0);

  tcp_word_t   acc_data_q, acc_data_d;
  tcp_fill_t   acc_cnt_q,  acc_cnt_d;
  logic        acc_closed_q, acc_closed_d;
  logic [15:0] timer_q,    timer_d;
  tcp_word_t   tx_data_q,  tx_data_d;
  tcp_cnt_t    tx_cnt_q,   tx_cnt_d;
  logic        tx_valid_q, tx_valid_d;

  logic        in_ready_w;
  logic        accept_w;
  logic        out_free_w;
  logic        timeout_w;
  logic        close_w;
  tcp_word_t   word_w;
  tcp_fill_t   fill_w;
  logic [16:0] timer_inc_w;

  assign in_ready_w  = con_ready && !acc_closed_q;
  assign accept_w    = bus.in_valid && in_ready_w;
  assign out_free_w  = !tx_valid_q || bus.tx_ready;
  assign timer_inc_w = {1'b0, timer_q} + 17'd1;

  // An accepted byte in the same cycle pre-empts the timeout.
  assign timeout_w = TIMEOUT_EN && !accept_w && !acc_closed_q &&
                     (acc_cnt_q != 4'd0) && (timer_inc_w == TIMEOUT_L);

  assign word_w  = accept_w ? (acc_data_q | place_byte(bus.in_data, acc_cnt_q[2:0])) : acc_data_q;
  assign fill_w  = acc_cnt_q + {3'b000, accept_w};
  assign close_w = timeout_w || (accept_w && (bus.in_last || acc_cnt_q == 4'd7));

  always_comb begin
    acc_data_d   = acc_data_q;
    acc_cnt_d    = acc_cnt_q;
    acc_closed_d = acc_closed_q;
    timer_d      = timer_q;
    tx_data_d    = tx_data_q;
    tx_cnt_d     = tx_cnt_q;
    tx_valid_d   = tx_valid_q;

    if (tx_valid_q && bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end

    if (!con_ready) begin
      // tcp drops everything while disconnected, so pending data is discarded.
      acc_data_d   = '0;
      acc_cnt_d    = '0;
      acc_closed_d = 1'b0;
      timer_d      = '0;
      tx_data_d    = '0;
      tx_cnt_d     = '0;
      tx_valid_d   = 1'b0;
    end else if (acc_closed_q) begin
      if (out_free_w) begin
        tx_data_d    = acc_data_q;
        tx_cnt_d     = tcp_cnt_t'(acc_cnt_q - 4'd1);
        tx_valid_d   = 1'b1;
        acc_data_d   = '0;
        acc_cnt_d    = '0;
        acc_closed_d = 1'b0;
      end
      timer_d = '0;
    end else if (close_w) begin
      if (out_free_w) begin
        tx_data_d  = word_w;
        tx_cnt_d   = tcp_cnt_t'(fill_w - 4'd1);
        tx_valid_d = 1'b1;
        acc_data_d = '0;
        acc_cnt_d  = '0;
      end else begin
        acc_data_d   = word_w;
        acc_cnt_d    = fill_w;
        acc_closed_d = 1'b1;
      end
      timer_d = '0;
    end else begin
      acc_data_d = word_w;
      acc_cnt_d  = fill_w;
      if (accept_w || acc_cnt_q == 4'd0) begin
        timer_d = '0;
      end else begin
        timer_d = timer_inc_w[15:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data_q   <= '0;
      acc_cnt_q    <= '0;
      acc_closed_q <= 1'b0;
      timer_q      <= '0;
      tx_data_q    <= '0;
      tx_cnt_q     <= '0;
      tx_valid_q   <= 1'b0;
    end else begin
      acc_data_q   <= acc_data_d;
      acc_cnt_q    <= acc_cnt_d;
      acc_closed_q <= acc_closed_d;
      timer_q      <= timer_d;
      tx_data_q    <= tx_data_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_valid_q   <= tx_valid_d;
    end
  end

  assign bus.in_ready = in_ready_w;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_cnt   = tx_cnt_q;
  assign bus.tx_valid = tx_valid_q;

endmodule
`default_nettype wire

// File: doc/tcp_tx_packer.md
# tcp_tx_packer

Byte-to-word packer feeding the transmit side of `tcp`. It accepts an 8-bit byte stream with a valid/ready handshake and packs it MSB-first into 64-bit words on the `tx_data`/`tx_valid`/`tx_ready`/`tx_cnt` interface that `tcp` consumes. A partial word is closed early on `in_last` or after a programmable idle timeout, so short messages are not held back. Input is blocked while the TCP connection is down.

## Interface
Parameters:
- `FLUSH_TIMEOUT`, default 64: idle cycles after which a partial word is closed. 0 disables the timeout. Range 0..65535.

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset, asynchronous, active-high
- `con_ready`  in  1  TCP connection established (from `tcp`)
- `in_data`  in  8  input byte
- `in_valid`  in  1  byte valid
- `in_last`  in  1  this byte ends a message; close the word after it
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`
- `tx_data`  out  64  packed word; first byte in [63:56], unused lanes zero
- `tx_cnt`  out  3  number of valid bytes minus 1
- `tx_valid`  out  1  word valid
- `tx_ready`  in  1  word accepted when `tx_valid && tx_ready`

## Operation
- Two storage stages:
  - accumulator: `acc_data[63:0]`, `acc_cnt` 0..8, `acc_closed`.
  - output register: `tx_data`, `tx_cnt`, `tx_valid`.
- Byte placement: the byte accepted with `acc_cnt = n` is written to bits [63-8n : 56-8n].
- A word closes when any of these occurs:
  - the 8th byte is accepted;
  - an accepted byte has `in_last = 1`;
  - a timeout fires.
- On close:
  - If the output register is free (`!tx_valid`, or `tx_ready` this cycle), the word and `cnt-1` are loaded into it at the same edge and the accumulator clears.
  - Otherwise `acc_closed = 1` and the word waits in the accumulator.
- A waiting closed word moves to the output register on the first edge where the output register is free.
- `in_ready = con_ready && !acc_closed`.
- Idle timer (16 bit):
  - cleared on every accepted byte and whenever `acc_cnt = 0`;
  - otherwise increments each cycle;
  - when it would reach `FLUSH_TIMEOUT`, the word closes.
- Empty words are never produced. `in_last` arriving on the 8th byte produces one word with `tx_cnt = 7`.
- If `con_ready` is low:
  - `in_ready = 0`;
  - accumulator, timer and output register are cleared, so `tx_valid` drops without a handshake. This is the only permitted violation of valid stability, because `tcp` discards data when the connection is down.

## Timing
- Reset values: `in_ready = 0` (follows `con_ready` after reset), `tx_valid = 0`, `tx_data = 0`, `tx_cnt = 0`. Accumulator, timer and `acc_closed` are zero.
- Latency: closing byte accepted at edge k gives `tx_valid = 1` after edge k if the output register is free. Otherwise the word follows on the edge after the output register drains.
- Timeout: last byte accepted at edge k gives `tx_valid` after edge k + `FLUSH_TIMEOUT` (output register free).
- Once `tx_valid` is high, `tx_data` and `tx_cnt` hold until `tx_ready` (except for the `con_ready` drop).
- Throughput: one byte per cycle sustained while `tx_ready` is high. With `tx_ready` held low, at most 16 bytes are accepted, then `in_ready = 0`.
- Simultaneous events:
  - byte accept and timeout in the same cycle: the byte wins and the timer clears;
  - close and output drain in the same cycle: the load happens in that cycle;
  - `rst` mid-word discards all state immediately.

## Structure
- The shared package `tcp_pkg` holds:
  - `BYTE_LANES = 8`;
  - `typedef logic [63:0] tcp_word_t`;
  - `typedef logic [2:0] tcp_cnt_t`.
- `tcp` and its neighbouring stages reuse these.
- Single module, no sub-modules. The idle timer is inline.

## Test plan
- Bytes 11..88 back-to-back, `tx_ready = 1` -> one word `1122334455667788`, `tx_cnt = 7`, `tx_valid` the cycle after the 8th byte.
- Bytes 66,77,88 with `in_last` on 88 -> `6677880000000000`, `tx_cnt = 2`.
- `FLUSH_TIMEOUT = 10`, bytes AA,BB then idle -> `AABB000000000000`, `tx_cnt = 1`, exactly 10 cycles after BB is accepted. No word if a byte arrives on cycle 9.
- `tx_ready = 0`, 20 bytes offered -> 16 accepted, then `in_ready = 0`. Release `tx_ready` -> two words in order, then the remaining 4 bytes are accepted.
- `con_ready` dropped after 5 bytes with a word pending -> `tx_valid = 0`, state cleared. After reconnect, 8 new bytes give one clean word.
- `rst` pulsed mid-word -> all outputs return to reset values at once. No stale bytes in the next word.
